outp_dispense_pulse: RTL and testbench
======================================

# outp_dispense_pulse

Avalon-MM slave output port that drives the vending machine's dispense actuator with a timed, software-programmed pulse, then flags completion by edge-captured interrupt. Output-side counterpart to the button-input ports: the CPU handles a confirm-buy input, then commands a dispense pulse here. Sits on the Nios II system interconnect, one instance per actuator line.

## Interface
- LEN_W, 16: width of pulse-length register, down-counter, writedata and readdata.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  LEN_W  write data.
- readdata  out  LEN_W  registered read data.
- irq  out  1  interrupt request.
- out_port  out  1  actuator drive, registered.

## Operation
- Write strobe: chipselect && !write_n. Reads have no side effects.
- Register map:
  - Address 0, CTRL/STATUS:
    - Write: bit0 = START, bit1 = ABORT (ABORT only with macro).
    - Read: bit0 = out_port, bit1 = busy, other bits 0.
  - Address 1, LEN: R/W, full LEN_W bits, pulse length in clk cycles.
  - Address 2, IRQ_MASK: R/W bit0, other bits read 0.
  - Address 3, DONE: read bit0 = done_capture; any write clears it.
- FSM, two states:
  - IDLE: out_port=0, busy=0.
    - START with LEN≠0 → PULSE; count loads LEN.
    - START with LEN=0 is ignored: no pulse, no done.
  - PULSE: out_port=1, busy=1; count decrements each cycle.
    - When count==1 at a clk edge → IDLE, out_port=0, done_capture set.
    - START while in PULSE is ignored; the pulse is not restarted or extended.
- A LEN write during PULSE updates the register only; the running pulse keeps its loaded count.
- irq = done_capture & irq_mask, combinational.
- Simultaneous DONE clear and new done set in the same cycle: set wins.
- Reset mid-pulse: out_port drops asynchronously; FSM returns to IDLE; no done.
- Reset values:
  - out_port=0, readdata=0, irq=0.
  - LEN=0, count=0, irq_mask=0, done_capture=0, state IDLE.

## Timing
- readdata is registered every clk from the address mux, independent of chipselect. Data for the address presented at edge N is valid after edge N.
- A START write sampled at edge T gives out_port=1 from edge T through edge T+LEN. out_port falls at edge T+LEN, so it is high for exactly LEN cycles.
- done_capture, and irq if masked, rises at the same edge T+LEN. The earliest accepted next START is at edge T+LEN.
- Maximum pulse length is 2^LEN_W−1 cycles. No wrap: count never decrements below 1 in PULSE.

## Configuration
- OUTP_DISPENSE_ABORT_EN defined:
  - A CTRL write with bit1=1 during PULSE forces IDLE and out_port=0 at the next edge. done_capture is not set.
  - bit1=1 always suppresses START in the same write, whether IDLE or PULSE.
- OUTP_DISPENSE_ABORT_EN undefined: bit1 is ignored. A pulse always runs to completion unless reset is asserted.

## Test plan
- Basic pulse:
  - Stimulus: LEN=5, IRQ_MASK=1, START at edge T.
  - Response: out_port high for exactly 5 cycles (edges T..T+5); done and irq rise at T+5; CTRL reads 0x0.
- Ignored starts:
  - Stimulus: LEN=0 then START; separately, LEN=10, START, then START again 3 cycles later.
  - Response: no pulse and done stays 0 for LEN=0; second start ignored, single 10-cycle pulse.
- Mid-pulse LEN write:
  - Stimulus: LEN=8, START, write LEN=2 at cycle 3.
  - Response: pulse still 8 cycles; LEN reads 2.
- Done clear race:
  - Stimulus: DONE cleared via a write at address 3 in the same cycle a pulse ends.
  - Response: done_capture=1, irq=1 with mask set. A later write at address 3 clears irq to 0.
- Reset mid-pulse:
  - Stimulus: reset_n asserted low at cycle 4 of a 20-cycle pulse.
  - Response: out_port=0 immediately; all registers read 0 after release.
- Abort (with OUTP_DISPENSE_ABORT_EN):
  - Stimulus: write 0x2 to CTRL at cycle 3 of a 20-cycle pulse.
  - Response: out_port low next edge, busy=0, done=0. Writing 0x3 while idle starts nothing.

Source files
------------

// File: rtl/outp_dispense_pulse.sv
// Avalon-MM output port driving a dispense actuator with a programmed-length pulse
// and an edge-captured completion interrupt. Optional abort: `define OUTP_DISPENSE_ABORT_EN.
module outp_dispense_pulse #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [LEN_W-1:0] writedata,
  output logic [LEN_W-1:0] readdata,
  output logic             irq,
  output logic             out_port
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_PULSE = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_LEN  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_DONE = 2'd3;

  state_t           r_state;
  state_t           w_next_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_next_count;
  logic             r_mask;
  logic             r_done;
  logic             r_out;
  logic [LEN_W-1:0] r_readdata;
  logic             w_wr;
  logic             w_ctrl_wr;
  logic             w_start;
  logic             w_abort;
  logic             w_done_set;
  logic             w_busy;
  logic [LEN_W-1:0] w_rd_mux;

  assign w_wr      = chipselect & ~write_n;
  assign w_ctrl_wr = w_wr && (address == ADDR_CTRL);

`ifdef OUTP_DISPENSE_ABORT_EN
  assign w_abort = w_ctrl_wr & writedata[1];
`else
  assign w_abort = 1'b0;
`endif

  // ABORT in the same write always wins over START.
  assign w_start = w_ctrl_wr & writedata[0] & ~w_abort;
  assign w_busy  = (r_state == S_PULSE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_next_state = r_state;
    w_next_count = r_count;
    w_done_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start && (r_len != '0)) begin
          w_next_state = S_PULSE;
          w_next_count = r_len;
        end
      end
      S_PULSE: begin
        if (w_abort) begin
          w_next_state = S_IDLE;
          w_next_count = '0;
        end else if (r_count == LEN_W'(1)) begin
          // Final cycle: completion is flagged, and a START landing here is the first one accepted.
          w_done_set = 1'b1;
          if (w_start && (r_len != '0)) begin
            w_next_count = r_len;
          end else begin
            w_next_state = S_IDLE;
            w_next_count = '0;
          end
        end else begin
          w_next_count = r_count - LEN_W'(1);
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_count = '0;
      end
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    unique case (address)
      ADDR_CTRL: w_rd_mux = {{(LEN_W-2){1'b0}}, w_busy, r_out};
      ADDR_LEN:  w_rd_mux = r_len;
      ADDR_MASK: w_rd_mux = {{(LEN_W-1){1'b0}}, r_mask};
      ADDR_DONE: w_rd_mux = {{(LEN_W-1){1'b0}}, r_done};
      default:   w_rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_out      <= 1'b0;
      r_len      <= '0;
      r_mask     <= 1'b0;
      r_done     <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_state    <= w_next_state;
      r_count    <= w_next_count;
      r_out      <= (w_next_state == S_PULSE);
      r_readdata <= w_rd_mux;
      if (w_wr && (address == ADDR_LEN))  r_len  <= writedata;
      if (w_wr && (address == ADDR_MASK)) r_mask <= writedata[0];
      // A completion in the same cycle as a DONE write keeps the flag set.
      if (w_done_set)                          r_done <= 1'b1;
      else if (w_wr && (address == ADDR_DONE)) r_done <= 1'b0;
    end
  end

  assign out_port = r_out;
  assign readdata = r_readdata;
  assign irq      = r_done & r_mask;

endmodule

// File: tb/tb_outp_dispense_pulse.sv
// Self-checking bench for outp_dispense_pulse: queued expected pulse widths
// compared against measured actuator pulses, plus register and irq checks.
module tb_outp_dispense_pulse;

  localparam int LEN_W = 16;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [LEN_W-1:0] writedata;
  logic [LEN_W-1:0] readdata;
  logic             irq;
  logic             out_port;

  int total = 0;
  int bad   = 0;
  int hi_cnt = 0;
  int exp_q[$];

  outp_dispense_pulse #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts clock periods the actuator spends high, sampled mid-cycle.
  always @(negedge clk) if (out_port === 1'b1) hi_cnt++;

  task automatic bus_write(input logic [1:0] a, input logic [LEN_W-1:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [LEN_W-1:0] d);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(posedge clk); #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_low(input int base, output int width, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (out_port !== 1'b1) begin timeout = 1'b0; break; end
    end
    width = hi_cnt - base;
  endtask

  task automatic test_reset;
    logic [LEN_W-1:0] d;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    #12;
    total++;
    if (out_port !== 1'b0 || irq !== 1'b0 || readdata !== '0) begin
      bad++;
      $display("FAIL reset_outputs got out=%b irq=%b rd=%h want 0 0 0", out_port, irq, readdata);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      total++;
      if (d !== '0) begin
        bad++;
        $display("FAIL reset_reg%0d got=%h want=0", a, d);
      end
    end
  endtask

  task automatic test_basic;
    logic [LEN_W-1:0] d;
    int base, w, e;
    bit to;
    bus_write(2'd2, 16'h0001);
    bus_write(2'd1, 16'd5);
    base = hi_cnt;
    exp_q.push_back(5);
    bus_write(2'd0, 16'h0001);
    bus_read(2'd0, d);
    total++;
    if (d !== 16'h0003) begin bad++; $display("FAIL basic_ctrl_busy got=%h want=0003", d); end
    wait_low(base, w, to);
    e = exp_q.pop_front();
    total++;
    if (to || w !== e) begin bad++; $display("FAIL basic_width got=%0d want=%0d timeout=%0b", w, e, to); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq got=%b want=1", irq); end
    bus_read(2'd0, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL basic_ctrl_idle got=%h want=0000", d); end
    bus_read(2'd3, d);
    total++;
    if (d !== 16'h0001) begin bad++; $display("FAIL basic_done got=%h want=0001", d); end
    // Minimum-length pulse.
    bus_write(2'd3, 16'h0000);
    bus_write(2'd1, 16'd1);
    base = hi_cnt;
    exp_q.push_back(1);
    bus_write(2'd0, 16'h0001);
    wait_low(base, w, to);
    e = exp_q.pop_front();
    total++;
    if (to || w !== e) begin bad++; $display("FAIL len1_width got=%0d want=%0d timeout=%0b", w, e, to); end
  endtask

  task automatic test_ignored_starts;
    logic [LEN_W-1:0] d;
    int base, w, e;
    bit to;
    bus_write(2'd3, 16'h0000);
    bus_write(2'd1, 16'd0);
    base = hi_cnt;
    exp_q.push_back(0);
    bus_write(2'd0, 16'h0001);
    idle(6);
    e = exp_q.pop_front();
    total++;
    if (hi_cnt - base !== e) begin bad++; $display("FAIL zero_len_width got=%0d want=%0d", hi_cnt - base, e); end
    bus_read(2'd3, d);
    total++;
    if (d !== 16'h0000 || irq !== 1'b0) begin
      bad++; $display("FAIL zero_len_done got=%h irq=%b want 0000 0", d, irq);
    end
    bus_write(2'd1, 16'd10);
    base = hi_cnt;
    exp_q.push_back(10);
    bus_write(2'd0, 16'h0001);
    idle(2);
    bus_write(2'd0, 16'h0001);
    wait_low(base, w, to);
    e = exp_q.pop_front();
    total++;
    if (to || w !== e) begin bad++; $display("FAIL double_start_width got=%0d want=%0d timeout=%0b", w, e, to); end
  endtask

  task automatic test_len_write;
    logic [LEN_W-1:0] d;
    int base, w, e;
    bit to;
    bus_write(2'd1, 16'd8);
    base = hi_cnt;
    exp_q.push_back(8);
    bus_write(2'd0, 16'h0001);
    idle(2);
    bus_write(2'd1, 16'd2);
    wait_low(base, w, to);
    e = exp_q.pop_front();
    total++;
    if (to || w !== e) begin bad++; $display("FAIL len_write_width got=%0d want=%0d timeout=%0b", w, e, to); end
    bus_read(2'd1, d);
    total++;
    if (d !== 16'd2) begin bad++; $display("FAIL len_readback got=%0d want=2", d); end
  endtask

  task automatic test_done_race;
    logic [LEN_W-1:0] d;
    int base, w, e;
    bit to;
    bus_write(2'd2, 16'h0001);
    bus_write(2'd3, 16'h0000);
    bus_write(2'd1, 16'd4);
    base = hi_cnt;
    exp_q.push_back(4);
    bus_write(2'd0, 16'h0001);
    idle(3);
    bus_write(2'd3, 16'h0000);
    total++;
    if (out_port !== 1'b0 || irq !== 1'b1) begin
      bad++; $display("FAIL race_end got out=%b irq=%b want 0 1", out_port, irq);
    end
    wait_low(base, w, to);
    e = exp_q.pop_front();
    total++;
    if (to || w !== e) begin bad++; $display("FAIL race_width got=%0d want=%0d timeout=%0b", w, e, to); end
    bus_read(2'd3, d);
    total++;
    if (d !== 16'h0001) begin bad++; $display("FAIL race_done got=%h want=0001", d); end
    bus_write(2'd3, 16'h0000);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL race_clear_irq got=%b want=0", irq); end
  endtask

  task automatic test_reset_mid_pulse;
    logic [LEN_W-1:0] d;
    bus_write(2'd1, 16'd20);
    bus_write(2'd0, 16'h0001);
    idle(3);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (out_port !== 1'b0 || irq !== 1'b0) begin
      bad++; $display("FAIL reset_mid_async got out=%b irq=%b want 0 0", out_port, irq);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      total++;
      if (d !== '0) begin bad++; $display("FAIL reset_mid_reg%0d got=%h want=0", a, d); end
    end
    idle(3);
    total++;
    if (out_port !== 1'b0) begin bad++; $display("FAIL reset_mid_stays_low got=%b want=0", out_port); end
  endtask

`ifdef OUTP_DISPENSE_ABORT_EN
  task automatic test_abort;
    logic [LEN_W-1:0] d;
    int base;
    bus_write(2'd1, 16'd20);
    bus_write(2'd0, 16'h0001);
    idle(2);
    bus_write(2'd0, 16'h0002);
    total++;
    if (out_port !== 1'b0) begin bad++; $display("FAIL abort_out got=%b want=0", out_port); end
    bus_read(2'd0, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL abort_ctrl got=%h want=0000", d); end
    bus_read(2'd3, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL abort_done got=%h want=0000", d); end
    base = hi_cnt;
    exp_q.push_back(0);
    bus_write(2'd0, 16'h0003);
    idle(4);
    total++;
    if (hi_cnt - base !== exp_q.pop_front()) begin
      bad++; $display("FAIL abort_suppress_start got=%0d want=0", hi_cnt - base);
    end
  endtask
`else
  task automatic test_abort;
    logic [LEN_W-1:0] d;
    int base, w, e;
    bit to;
    bus_write(2'd1, 16'd6);
    base = hi_cnt;
    exp_q.push_back(6);
    bus_write(2'd0, 16'h0001);
    idle(1);
    bus_write(2'd0, 16'h0002);
    wait_low(base, w, to);
    e = exp_q.pop_front();
    total++;
    if (to || w !== e) begin bad++; $display("FAIL no_abort_width got=%0d want=%0d timeout=%0b", w, e, to); end
    bus_read(2'd3, d);
    total++;
    if (d !== 16'h0001) begin bad++; $display("FAIL no_abort_done got=%h want=0001", d); end
    bus_write(2'd3, 16'h0000);
    bus_write(2'd1, 16'd3);
    base = hi_cnt;
    exp_q.push_back(3);
    bus_write(2'd0, 16'h0003);
    wait_low(base, w, to);
    e = exp_q.pop_front();
    total++;
    if (to || w !== e) begin bad++; $display("FAIL bit1_ignored_width got=%0d want=%0d timeout=%0b", w, e, to); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignored_starts();
    test_len_write();
    test_done_race();
    test_reset_mid_pulse();
    test_abort();
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
